// File: rtl/seq_pkg.sv
// Shared definitions for the light-stick sequence checker.
// Contents: FSM state encoding, default last-legal-state constant and the
//           wrap-around successor function used for the expected value.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_MAX_STATE = 6;

  // Successor in the cyclic sequence 0..max_s.
  function automatic logic [3:0] seq_next(input logic [3:0] x, input logic [3:0] max_s);
    return (x == max_s) ? 4'd0 : x + 4'd1;
  endfunction

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: i_clk clock, i_clr synchronous clear (wins over increment),
//        i_inc increment enable, o_cnt registered count (sticks at all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_checker.sv
// Receive-side checker for the cyclic light-stick state sequence 0..MAX_STATE.
// Ports: clk/rst (sync, active-high); state_in/state_vld sample stream;
//        locked, err (1-cycle pulse), err_cnt (saturating), frame_cnt (wrapping),
//        expected (next value anticipated). All outputs registered.
// Build option: SEQ_CHECK_REPEAT_EN makes a repeat of the last accepted value
//        a hold (no advance, no error) while in SYNC or LOCKED.
module seq_checker
  import seq_pkg::*;
#(
  parameter int MAX_STATE = DEF_MAX_STATE,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_W     = 8,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         state_in,
  input  logic               state_vld,
  output logic               locked,
  output logic               err,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [3:0]         expected
);

  localparam logic [3:0] MAX_S  = 4'(MAX_STATE);
  localparam logic [3:0] LOCK_S = 4'(LOCK_CNT);
`ifdef SEQ_CHECK_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  seq_state_e         r_state, w_state_nxt;
  logic [3:0]         r_expected, w_exp_nxt;
  logic [3:0]         r_good, w_good_nxt;
  logic [3:0]         r_last, w_last_nxt;
  logic               r_locked, r_err;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               w_err_ev, w_frame_inc;
  logic               w_legal, w_match, w_hold, w_lock_done;
  logic [3:0]         w_seed, w_good_inc;

  assign w_legal     = (state_in <= MAX_S);
  assign w_match     = (state_in == r_expected);
  // r_last always holds a seeded/accepted value in SYNC/LOCKED, and
  // next(x) != x, so a hold can never shadow a genuine match.
  assign w_hold      = REPEAT_EN && (state_in == r_last);
  assign w_seed      = seq_next(state_in, MAX_S);
  assign w_good_inc  = r_good + 4'd1;
  assign w_lock_done = (w_good_inc == LOCK_S);

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_expected;
    w_good_nxt  = r_good;
    w_last_nxt  = r_last;
    w_err_ev    = 1'b0;
    w_frame_inc = 1'b0;
    if (state_vld) begin
      case (r_state)
        ST_HUNT: begin
          if (w_legal) begin
            w_state_nxt = ST_SYNC;
            w_exp_nxt   = w_seed;
            w_good_nxt  = 4'd0;
            w_last_nxt  = state_in;
          end
        end
        ST_SYNC: begin
          if (w_match) begin
            w_exp_nxt  = w_seed;
            w_good_nxt = w_good_inc;
            w_last_nxt = state_in;
            if (w_lock_done) begin
              w_state_nxt = ST_LOCKED;
              // The sample that completes lock already counts as locked.
              w_frame_inc = (state_in == MAX_S);
            end
          end else if (!w_hold) begin
            w_good_nxt = 4'd0;
            if (w_legal) begin
              w_exp_nxt  = w_seed;
              w_last_nxt = state_in;
            end else begin
              w_state_nxt = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_exp_nxt   = w_seed;
            w_last_nxt  = state_in;
            w_frame_inc = (state_in == MAX_S);
          end else if (!w_hold) begin
            w_err_ev   = 1'b1;
            w_good_nxt = 4'd0;
            if (w_legal) begin
              w_state_nxt = ST_SYNC;
              w_exp_nxt   = w_seed;
              w_last_nxt  = state_in;
            end else begin
              w_state_nxt = ST_HUNT;
            end
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_good_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_expected  <= 4'd0;
      r_good      <= 4'd0;
      r_last      <= 4'd0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_exp_nxt;
      r_good     <= w_good_nxt;
      r_last     <= w_last_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_err      <= w_err_ev;
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .i_clk (clk),
    .i_clr (rst),
    .i_inc (w_err_ev),
    .o_cnt (err_cnt)
  );

  assign locked    = r_locked;
  assign err       = r_err;
  assign frame_cnt = r_frame_cnt;
  assign expected  = r_expected;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker (MAX_STATE=6, LOCK_CNT=3, ERR_W=2, FRAME_W=8).
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_in;
  logic       state_vld;
  logic       locked, err;
  logic [1:0] err_cnt;
  logic [7:0] frame_cnt;
  logic [3:0] expected;

  int n_chk  = 0;
  int n_fail = 0;

  seq_checker #(
    .MAX_STATE (6),
    .LOCK_CNT  (3),
    .ERR_W     (2),
    .FRAME_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .state_vld (state_vld),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .frame_cnt (frame_cnt),
    .expected  (expected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One valid sample; outputs are observed 1 time unit after the edge.
  task automatic smp(input logic [3:0] v);
    state_in  = v;
    state_vld = 1'b1;
    @(posedge clk);
    #1;
    state_vld = 1'b0;
  endtask

  // Idle cycle with garbage on the data lines.
  task automatic idle();
    state_in  = 4'($urandom_range(0, 15));
    state_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic l, input logic e,
                           input logic [1:0] ec, input logic [7:0] fc, input logic [3:0] ex);
    check({tag, ".locked"},    32'(locked),    32'(l));
    check({tag, ".err"},       32'(err),       32'(e));
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(fc));
    check({tag, ".expected"},  32'(expected),  32'(ex));
  endtask

  initial begin
    // Reset held with valid samples present: reset must win.
    rst = 1'b1; state_in = 4'd5; state_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 2'd0, 8'd0, 4'd0);
    rst = 1'b0; state_vld = 1'b0;
    idle();

    // Acquire: seed 0, then three correct transitions.
    smp(4'd0); smp(4'd1); smp(4'd2);
    check("acq.not_yet", 32'(locked), 32'd0);
    smp(4'd3);
    check_all("acq", 1'b1, 1'b0, 2'd0, 8'd0, 4'd4);
    idle(); idle();
    check_all("idle_hold", 1'b1, 1'b0, 2'd0, 8'd0, 4'd4);

    // Wrap while locked.
    smp(4'd4); smp(4'd5); smp(4'd6);
    check("wrap.frame_at6", 32'(frame_cnt), 32'd1);
    smp(4'd0);
    check_all("wrap", 1'b1, 1'b0, 2'd0, 8'd1, 4'd1);

    // Out-of-order while locked, expected=3, sample 5.
    smp(4'd1); smp(4'd2);
    smp(4'd5);
    check_all("oor", 1'b0, 1'b1, 2'd1, 8'd1, 4'd6);
    idle();
    check("oor.pulse_end", 32'(err), 32'd0);
    // Reseeded into SYNC: three matches relock (6 here does not bump frames).
    smp(4'd6); smp(4'd0); smp(4'd1);
    check_all("relock1", 1'b1, 1'b0, 2'd1, 8'd1, 4'd2);

    // Illegal value while locked -> HUNT.
    smp(4'd9);
    check_all("illegal_lk", 1'b0, 1'b1, 2'd2, 8'd1, 4'd2);
    smp(4'd9);
    check_all("illegal_hunt", 1'b0, 1'b0, 2'd2, 8'd1, 4'd2);
    // From HUNT the 2 only seeds, so lock needs 3,4,5.
    smp(4'd2); smp(4'd3); smp(4'd4);
    check("hunt.seed_only", 32'(locked), 32'd0);
    smp(4'd5);
    check_all("relock2", 1'b1, 1'b0, 2'd2, 8'd1, 4'd6);

    // Saturation of the 2-bit error counter.
    smp(4'd0);
    check_all("sat.e3", 1'b0, 1'b1, 2'd3, 8'd1, 4'd1);
    smp(4'd1); smp(4'd2); smp(4'd3); smp(4'd4);
    check("sat.relock", 32'(locked), 32'd1);
    smp(4'd3);
    check_all("sat.e4", 1'b0, 1'b1, 2'd3, 8'd1, 4'd4);
    // Lock completes on the MAX_STATE sample: frame counts it.
    smp(4'd4); smp(4'd5); smp(4'd6);
    check_all("lock_on_max", 1'b1, 1'b0, 2'd3, 8'd2, 4'd0);

    // Repeated sample while locked.
    smp(4'd0); smp(4'd1); smp(4'd2); smp(4'd3); smp(4'd4);
    check("rep.first", 32'(expected), 32'd5);
    smp(4'd4);
`ifdef SEQ_CHECK_REPEAT_EN
    check_all("rep.hold", 1'b1, 1'b0, 2'd3, 8'd2, 4'd5);
`else
    check_all("rep.err", 1'b0, 1'b1, 2'd3, 8'd2, 4'd5);
`endif

    // Reset with a valid sample in the same cycle.
    rst = 1'b1; state_in = 4'd5; state_vld = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; state_vld = 1'b0;
    check_all("mid_rst", 1'b0, 1'b0, 2'd0, 8'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
